// File: rtl/sb_xbee_pkg.sv
// rtl/sb_xbee_pkg.sv - shared constants, state encoding and helpers for the Xbee message scheduler
//
// Purpose: ASCII constants, message type codes, FSM state encoding, message
//          lengths and the request-validity check shared by the scheduler and
//          the message builder.
// Ports:   none (package).
// Config:  SB_XBEE_CHECKSUM_EN adds one XOR checksum byte before '\n',
//          lengthening both message types by one byte.
package sb_xbee_pkg;

  localparam logic [7:0] CHAR_G    = 8'h47;
  localparam logic [7:0] CHAR_B    = 8'h42;
  localparam logic [7:0] CHAR_I    = 8'h49;
  localparam logic [7:0] CHAR_E    = 8'h45;
  localparam logic [7:0] CHAR_N    = 8'h4E;
  localparam logic [7:0] CHAR_D    = 8'h44;
  localparam logic [7:0] CHAR_M    = 8'h4D;
  localparam logic [7:0] CHAR_W    = 8'h57;
  localparam logic [7:0] CHAR_DASH = 8'h2D;
  localparam logic [7:0] CHAR_HASH = 8'h23;
  localparam logic [7:0] CHAR_NL   = 8'h0A;
  localparam logic [7:0] CHAR_0    = 8'h30;

  localparam logic [1:0] MSG_GBI = 2'd1;
  localparam logic [1:0] MSG_END = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

`ifdef SB_XBEE_CHECKSUM_EN
  localparam logic [3:0] LEN_GBI = 4'd10;
  localparam logic [3:0] LEN_END = 4'd7;
`else
  localparam logic [3:0] LEN_GBI = 4'd9;
  localparam logic [3:0] LEN_END = 4'd6;
`endif

  // END carries no colour or bin, so only GBI checks those fields.
  function automatic logic msg_valid(input logic [1:0] msg_type,
                                     input logic [1:0] colour,
                                     input logic [3:0] bin);
    return ((msg_type == MSG_GBI) && (colour != 2'd3) && (bin <= 4'd8)) ||
           (msg_type == MSG_END);
  endfunction

endpackage

// File: rtl/sb_xbee_msg_builder.sv
// rtl/sb_xbee_msg_builder.sv - combinational message byte lookup
//
// Purpose: maps (type, colour, bin, index) of a validated request to the
//          ASCII byte at that index and flags the final byte.
// Ports:   msg_type, colour, bin - latched request fields
//          idx                   - byte index within the message
//          data                  - ASCII byte at idx
//          last                  - idx is the final ('\n') byte
//          is_csum               - idx is the checksum slot (SB_XBEE_CHECKSUM_EN only)
// Config:  SB_XBEE_CHECKSUM_EN reserves the slot before '\n' for the checksum,
//          whose value is supplied by the scheduler.
module sb_xbee_msg_builder
  import sb_xbee_pkg::*;
(
  input  logic [1:0] msg_type,
  input  logic [1:0] colour,
  input  logic [3:0] bin,
  input  logic [3:0] idx,
  output logic [7:0] data,
  output logic       last
`ifdef SB_XBEE_CHECKSUM_EN
  ,
  output logic       is_csum
`endif
);

  logic [3:0] len;
  logic [7:0] digit;
  logic [7:0] waste;

  always_comb begin
    len   = (msg_type == MSG_END) ? LEN_END : LEN_GBI;
    // Bin 0 is reported as '9'; 1..8 map straight onto their digit.
    digit = (bin == 4'd0) ? 8'h39 : (CHAR_0 + {4'd0, bin});
    case (colour)
      2'd0:    waste = CHAR_M;
      2'd1:    waste = CHAR_D;
      2'd2:    waste = CHAR_W;
      default: waste = 8'h00;
    endcase
  end

  always_comb begin
    data = 8'h00;
    last = 1'b0;
`ifdef SB_XBEE_CHECKSUM_EN
    is_csum = 1'b0;
`endif
    if (idx == len - 4'd1) begin
      data = CHAR_NL;
      last = 1'b1;
`ifdef SB_XBEE_CHECKSUM_EN
    end else if (idx == len - 4'd2) begin
      is_csum = 1'b1;
`endif
    end else if (msg_type == MSG_END) begin
      case (idx)
        4'd0:    data = CHAR_E;
        4'd1:    data = CHAR_N;
        4'd2:    data = CHAR_D;
        4'd3:    data = CHAR_DASH;
        4'd4:    data = CHAR_HASH;
        default: data = 8'h00;
      endcase
    end else begin
      case (idx)
        4'd0:    data = CHAR_G;
        4'd1:    data = CHAR_B;
        4'd2:    data = CHAR_I;
        4'd3:    data = digit;
        4'd4:    data = CHAR_DASH;
        4'd5:    data = waste;
        4'd6:    data = CHAR_DASH;
        4'd7:    data = CHAR_HASH;
        default: data = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/sb_xbee_msg_scheduler.sv
// rtl/sb_xbee_msg_scheduler.sv - round-robin message scheduler for the Xbee UART link
//
// Purpose: arbitrates N_REQ message sources round-robin, latches the winner's
//          fields, streams its ASCII message to the UART byte transmitter over
//          valid/ready, acks the source, then idles GAP_CYCLES cycles.
// Ports:   clk_50M, rst (sync, active-high)
//          req/req_type/req_colour/req_bin - per-source request and fields
//          byte_data/byte_valid/byte_ready - byte stream to the UART transmitter
//          ack/ack_err                     - completion pulse and invalid qualifier
//          busy, grant_id                  - status
// Config:  SB_XBEE_CHECKSUM_EN inserts an XOR checksum byte before '\n'.
module sb_xbee_msg_scheduler
  import sb_xbee_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int GAP_CYCLES = 434
) (
  input  logic                 clk_50M,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   req_type,
  input  logic [2*N_REQ-1:0]   req_colour,
  input  logic [4*N_REQ-1:0]   req_bin,
  output logic [7:0]           byte_data,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic [N_REQ-1:0]     ack,
  output logic                 ack_err,
  output logic                 busy,
  output logic [1:0]           grant_id
);

  state_t      state, state_nxt;
  logic [1:0]  rr_ptr;
  logic [1:0]  win_id;
  logic        win_found;
  logic [1:0]  cand;
  logic [1:0]  sel_type, sel_colour;
  logic [3:0]  sel_bin;
  logic        sel_valid;
  logic [1:0]  lat_type, lat_colour;
  logic [3:0]  lat_bin;
  logic [3:0]  idx;
  logic [15:0] gap_cnt;
  logic [7:0]  bld_data;
  logic        bld_last;
  logic        xfer;

`ifdef SB_XBEE_CHECKSUM_EN
  logic [7:0]  csum;
  logic        bld_csum;
`endif

  sb_xbee_msg_builder u_builder (
    .msg_type (lat_type),
    .colour   (lat_colour),
    .bin      (lat_bin),
    .idx      (idx),
    .data     (bld_data),
    .last     (bld_last)
`ifdef SB_XBEE_CHECKSUM_EN
    ,
    .is_csum  (bld_csum)
`endif
  );

  // Scan from rr_ptr+N down to rr_ptr+1 so the closest set bit after the
  // pointer is the last one written and therefore wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = rr_ptr;
    cand      = 2'd0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = 2'((int'(rr_ptr) + k) % N_REQ);
      if (req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Live fields of the granted source, sampled and validated during LOAD.
  always_comb begin
    sel_type   = req_type[2*int'(grant_id) +: 2];
    sel_colour = req_colour[2*int'(grant_id) +: 2];
    sel_bin    = req_bin[4*int'(grant_id) +: 4];
    sel_valid  = msg_valid(sel_type, sel_colour, sel_bin);
  end

  assign byte_valid = (state == ST_SEND);
  assign busy       = (state != ST_IDLE);
  assign xfer       = byte_valid && byte_ready;

`ifdef SB_XBEE_CHECKSUM_EN
  assign byte_data = bld_csum ? csum : bld_data;
`else
  assign byte_data = bld_data;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (win_found) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = sel_valid ? ST_SEND : ST_GAP;
      ST_SEND: if (xfer && bld_last) state_nxt = ST_GAP;
      ST_GAP:  if (gap_cnt == 16'(GAP_CYCLES - 1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= 2'd0;
      grant_id   <= 2'd0;
      idx        <= 4'd0;
      gap_cnt    <= 16'd0;
      ack        <= '0;
      ack_err    <= 1'b0;
      lat_type   <= 2'd0;
      lat_colour <= 2'd0;
      lat_bin    <= 4'd0;
`ifdef SB_XBEE_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      state   <= state_nxt;
      ack     <= '0;
      ack_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            grant_id <= win_id;
            rr_ptr   <= win_id;
          end
        end
        ST_LOAD: begin
          lat_type   <= sel_type;
          lat_colour <= sel_colour;
          lat_bin    <= sel_bin;
          idx        <= 4'd0;
          gap_cnt    <= 16'd0;
`ifdef SB_XBEE_CHECKSUM_EN
          csum       <= 8'h00;
`endif
          if (!sel_valid) begin
            ack[grant_id] <= 1'b1;
            ack_err       <= 1'b1;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            idx <= idx + 4'd1;
`ifdef SB_XBEE_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
            if (bld_last) begin
              ack[grant_id] <= 1'b1;
              gap_cnt       <= 16'd0;
            end
          end
        end
        ST_GAP: gap_cnt <= gap_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_xbee_msg_scheduler.sv
// tb/tb_sb_xbee_msg_scheduler.sv - directed self-checking bench for sb_xbee_msg_scheduler
module tb_sb_xbee_msg_scheduler;

  localparam int N_REQ = 3;
  localparam int GAP   = 434;

  typedef logic [7:0] bq_t[$];

  logic               clk_50M = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] req_type;
  logic [2*N_REQ-1:0] req_colour;
  logic [4*N_REQ-1:0] req_bin;
  logic [7:0]         byte_data;
  logic               byte_valid;
  logic               byte_ready;
  logic [N_REQ-1:0]   ack;
  logic               ack_err;
  logic               busy;
  logic [1:0]         grant_id;

  always #10 clk_50M = ~clk_50M;

  sb_xbee_msg_scheduler #(.N_REQ(N_REQ), .GAP_CYCLES(GAP)) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .req        (req),
    .req_type   (req_type),
    .req_colour (req_colour),
    .req_bin    (req_bin),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .ack        (ack),
    .ack_err    (ack_err),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  int  cyc = 0;
  bq_t byte_q;
  int  tcyc_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  always @(posedge clk_50M) cyc <= cyc + 1;

  // Transfer log: a byte moves on the coming edge when valid and ready are both high.
  always @(negedge clk_50M) begin
    if (!rst && byte_valid && byte_ready) begin
      byte_q.push_back(byte_data);
      tcyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t mk(input bq_t body);
    bq_t        m;
    logic [7:0] x;
    m = body;
    x = 8'h00;
    foreach (body[i]) x = x ^ body[i];
`ifdef SB_XBEE_CHECKSUM_EN
    m.push_back(x);
`endif
    m.push_back(8'h0A);
    return m;
  endfunction

  task automatic check_msg(input string tag, input bq_t exp);
    chk({tag, "_len"}, byte_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < byte_q.size()) chk($sformatf("%s_b%0d", tag, i), byte_q[i], exp[i]);
    end
    byte_q.delete();
    tcyc_q.delete();
  endtask

  task automatic set_src(input int s, input logic [1:0] t, input logic [1:0] c, input logic [3:0] b);
    req_type[2*s +: 2]   = t;
    req_colour[2*s +: 2] = c;
    req_bin[4*s +: 4]    = b;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_50M);
    #2;
  endtask

  task automatic wait_ack(output logic [N_REQ-1:0] a, output logic e, output int c);
    a = '0;
    e = 1'b0;
    c = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_50M);
      if (ack != '0) begin
        a = ack;
        e = ack_err;
        c = cyc;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_50M);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_idle"}, done, 1'b1);
    step(1);
  endtask

  initial begin
    logic [N_REQ-1:0] a;
    logic             e;
    int               c, r, nb, last_c, first_c, ack_c;
    logic [N_REQ-1:0] ack_v;
    logic             err_v;

    rst        = 1'b1;
    req        = '0;
    req_type   = '0;
    req_colour = '0;
    req_bin    = '0;
    byte_ready = 1'b1;
    step(2);
    @(negedge clk_50M);
    chk("rst_valid", byte_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 2'd0);
    chk("rst_ack", ack, 3'b000);
    chk("rst_ack_err", ack_err, 1'b0);
    step(1);
    rst = 1'b0;

    // Basic GBI from source 0, ready held high.
    set_src(0, 2'd1, 2'd0, 4'd1);
    req = 3'b001;
    r   = cyc;
    wait_ack(a, e, c);
    chk("t1_ack", a, 3'b001);
    chk("t1_ack_err", e, 1'b0);
    chk("t1_latency", (tcyc_q.size() > 0) ? (tcyc_q[0] - r) : -1, 2);
    chk("t1_contig", (tcyc_q.size() > 0) ? (tcyc_q[$] - tcyc_q[0]) : -1, byte_q.size() - 1);
    chk("t1_ack_cycle", (tcyc_q.size() > 0) ? (c - tcyc_q[$]) : -1, 1);
    check_msg("t1", mk('{8'h47, 8'h42, 8'h49, 8'h31, 8'h2D, 8'h4D, 8'h2D, 8'h23}));
    step(1);
    req = '0;
    wait_idle("t1");

    // Round robin: last grant 0, sources 0 and 2 together -> 2 first.
    set_src(0, 2'd1, 2'd0, 4'd1);
    set_src(2, 2'd1, 2'd1, 4'd2);
    req = 3'b101;
    wait_ack(a, e, c);
    chk("t2_ack_first", a, 3'b100);
    chk("t2_grant_first", grant_id, 2'd2);
    check_msg("t2a", mk('{8'h47, 8'h42, 8'h49, 8'h32, 8'h2D, 8'h44, 8'h2D, 8'h23}));
    step(1);
    req[2] = 1'b0;
    wait_ack(a, e, c);
    chk("t2_ack_second", a, 3'b001);
    chk("t2_grant_second", grant_id, 2'd0);
    check_msg("t2b", mk('{8'h47, 8'h42, 8'h49, 8'h31, 8'h2D, 8'h4D, 8'h2D, 8'h23}));
    step(1);
    req[0] = 1'b0;
    step(1);
    req[0] = 1'b1;
    wait_ack(a, e, c);
    chk("t2_ack_third", a, 3'b001);
    check_msg("t2c", mk('{8'h47, 8'h42, 8'h49, 8'h31, 8'h2D, 8'h4D, 8'h2D, 8'h23}));
    step(1);
    req = '0;
    wait_idle("t2");

    // Back-pressure: ready low for 5 cycles while index 3 ('4') is offered.
    set_src(1, 2'd1, 2'd0, 4'd4);
    req = 3'b010;
    step(5);
    byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_50M);
      chk($sformatf("t3_stall_valid%0d", i), byte_valid, 1'b1);
      chk($sformatf("t3_stall_data%0d", i), byte_data, 8'h34);
    end
    step(1);
    byte_ready = 1'b1;
    wait_ack(a, e, c);
    chk("t3_ack", a, 3'b010);
    check_msg("t3", mk('{8'h47, 8'h42, 8'h49, 8'h34, 8'h2D, 8'h4D, 8'h2D, 8'h23}));
    step(1);
    req = '0;
    wait_idle("t3");

    // Bin 0 / Blue mapping.
    set_src(1, 2'd1, 2'd2, 4'd0);
    req = 3'b010;
    wait_ack(a, e, c);
    chk("t4_ack", a, 3'b010);
    check_msg("t4", mk('{8'h47, 8'h42, 8'h49, 8'h39, 8'h2D, 8'h57, 8'h2D, 8'h23}));
    step(1);
    req = '0;
    wait_idle("t4");

    // Invalid bin: error ack, no bytes, busy for LOAD plus the full gap.
    set_src(1, 2'd1, 2'd0, 4'd10);
    req   = 3'b010;
    r     = cyc;
    nb    = 0;
    ack_v = '0;
    err_v = 1'b0;
    ack_c = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_50M);
      if (busy) nb++;
      if (ack != '0) begin
        ack_v = ack;
        err_v = ack_err;
        ack_c = cyc;
        req   = '0;
      end
      if (!busy && nb > 0) break;
    end
    chk("t4_err_busy_len", nb, GAP + 1);
    chk("t4_err_ack", ack_v, 3'b010);
    chk("t4_err_flag", err_v, 1'b1);
    chk("t4_err_ack_cycle", ack_c - r, 2);
    chk("t4_err_no_bytes", byte_q.size(), 0);
    step(1);

    // Reset while index 4 is on the link, then a fresh message.
    set_src(0, 2'd1, 2'd0, 4'd1);
    req = 3'b001;
    step(6);
    rst = 1'b1;
    byte_q.delete();
    tcyc_q.delete();
    step(1);
    rst = 1'b0;
    @(negedge clk_50M);
    chk("t5_valid_after_rst", byte_valid, 1'b0);
    chk("t5_busy_after_rst", busy, 1'b0);
    chk("t5_ack_after_rst", ack, 3'b000);
    wait_ack(a, e, c);
    chk("t5_ack", a, 3'b001);
    chk("t5_first_byte", (byte_q.size() > 0) ? byte_q[0] : 8'hFF, 8'h47);
    check_msg("t5", mk('{8'h47, 8'h42, 8'h49, 8'h31, 8'h2D, 8'h4D, 8'h2D, 8'h23}));
    step(1);
    req = '0;
    wait_idle("t5");

    // Back-to-back: END from source 1, then GBI from source 2 after the gap.
    set_src(1, 2'd2, 2'd0, 4'd0);
    set_src(2, 2'd1, 2'd0, 4'd1);
    req = 3'b110;
    wait_ack(a, e, c);
    chk("t6_ack_end", a, 3'b010);
    chk("t6_grant_end", grant_id, 2'd1);
    last_c = (tcyc_q.size() > 0) ? tcyc_q[$] : 0;
    check_msg("t6_end", mk('{8'h45, 8'h4E, 8'h44, 8'h2D, 8'h23}));
    step(1);
    req[1] = 1'b0;
    wait_ack(a, e, c);
    chk("t6_ack_gbi", a, 3'b100);
    first_c = (tcyc_q.size() > 0) ? tcyc_q[0] : 0;
    chk("t6_gap_respected", (first_c - last_c) >= (GAP + 2), 1'b1);
    check_msg("t6_gbi", mk('{8'h47, 8'h42, 8'h49, 8'h31, 8'h2D, 8'h4D, 8'h2D, 8'h23}));
    step(1);
    req = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
